fp_align_stage: RTL and testbench

Pre-add alignment stage of the FP adder. Accepts two IEEE-754 single-precision operands plus the add/sub opcode over a valid/ready handshake and unpacks them. Right-shifts the mantissa of the smaller-exponent operand over several cycles, and presents aligned 24-bit mantissas, the original signs, the opcode and the common exponent to the sign/operation logic stage directly downstream. Operand identity is preserved, never swapped: the downstream stage derives the result sign from a−b.

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_unpack.sv | 20 ++
 rtl/fp_align_stage.sv | 143 ++++++++++++++
 tb/tb_fp_align_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared widths, alignment constants and FSM encoding for the FP adder pipeline.
package fp_pkg;
    localparam int EXP_W       = 8;
    localparam int FRAC_W      = 23;
    localparam int MANT_W      = 24;
    localparam int ALIGN_CLAMP = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of an IEEE-754 single into sign, effective exponent,
// mantissa with hidden bit, and an Inf/NaN flag.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       word,
    output logic              sign,
    output logic [EXP_W-1:0]  exp_eff,
    output logic [MANT_W-1:0] mant,
    output logic              special
);
    logic [EXP_W-1:0] field;

    assign field   = word[30:23];
    assign sign    = word[31];
    // Denormals share the scale of exponent 1 but lack the hidden bit.
    assign exp_eff = (field == '0) ? EXP_W'(1) : field;
    assign mant    = {field != '0, word[FRAC_W-1:0]};
    assign special = (field == '1);
endmodule

// File: rtl/fp_align_stage.sv
// FP adder pre-add alignment: unpacks both operands and right-shifts the
// smaller-exponent mantissa STEP bits per cycle, collecting a sticky bit.
module fp_align_stage
    import fp_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_a_sign,
    output logic              out_b_sign,
    output logic [MANT_W-1:0] out_a_mant,
    output logic [MANT_W-1:0] out_b_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_op,
    output logic              out_sticky,
    output logic              out_special
);
    localparam logic [EXP_W-1:0] STEP_K = EXP_W'(STEP);
    localparam logic [EXP_W-1:0] CLAMP  = EXP_W'(ALIGN_CLAMP);

    state_t           state_reg;
    logic [EXP_W-1:0] rem_reg;
    logic             shift_b_reg;

    logic [31:0]       word_u [2];
    logic              sign_u [2];
    logic [EXP_W-1:0]  exp_u  [2];
    logic [MANT_W-1:0] mant_u [2];
    logic              spec_u [2];

    assign word_u[0] = in_a;
    assign word_u[1] = in_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            fp_unpack u_unpack (
                .word    (word_u[gi]),
                .sign    (sign_u[gi]),
                .exp_eff (exp_u[gi]),
                .mant    (mant_u[gi]),
                .special (spec_u[gi])
            );
        end
    endgenerate

    logic             a_smaller;
    logic [EXP_W-1:0] diff;
    logic [EXP_W-1:0] exp_max;
    logic             special_in;

    assign a_smaller  = exp_u[0] < exp_u[1];
    assign diff       = a_smaller ? (exp_u[1] - exp_u[0]) : (exp_u[0] - exp_u[1]);
    assign exp_max    = a_smaller ? exp_u[1] : exp_u[0];
    assign special_in = spec_u[0] | spec_u[1];

    logic [EXP_W-1:0]  step_k;
    logic [MANT_W-1:0] shift_src;
    logic [MANT_W-1:0] shifted;
    logic              step_lost;

    // One shift step: k = min(STEP, rem); lost bits feed the sticky flag.
    always_comb begin
        step_k    = (rem_reg < STEP_K) ? rem_reg : STEP_K;
        shift_src = shift_b_reg ? out_b_mant : out_a_mant;
        shifted   = shift_src >> step_k;
        step_lost = |(shift_src & ~({MANT_W{1'b1}} << step_k));
    end

    assign in_ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            shift_b_reg <= 1'b0;
            out_valid   <= 1'b0;
            out_a_sign  <= 1'b0;
            out_b_sign  <= 1'b0;
            out_a_mant  <= '0;
            out_b_mant  <= '0;
            out_exp     <= '0;
            out_op      <= 1'b0;
            out_sticky  <= 1'b0;
            out_special <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    out_a_sign  <= sign_u[0];
                    out_b_sign  <= sign_u[1];
                    out_a_mant  <= mant_u[0];
                    out_b_mant  <= mant_u[1];
                    out_exp     <= exp_max;
                    out_op      <= in_op;
                    out_special <= special_in;
                    out_sticky  <= 1'b0;
                    shift_b_reg <= !a_smaller;
                    rem_reg     <= diff;
                    if (special_in || diff == '0) begin
                        state_reg <= HOLD;
                        out_valid <= 1'b1;
                    end else if (diff >= CLAMP) begin
                        // Everything falls off the end; only the sticky survives.
                        if (a_smaller) begin
                            out_a_mant <= '0;
                            out_sticky <= |mant_u[0];
                        end else begin
                            out_b_mant <= '0;
                            out_sticky <= |mant_u[1];
                        end
                        state_reg <= HOLD;
                        out_valid <= 1'b1;
                    end else begin
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_b_reg) out_b_mant <= shifted;
                    else             out_a_mant <= shifted;
                    out_sticky <= out_sticky | step_lost;
                    rem_reg    <= rem_reg - step_k;
                    if (rem_reg == step_k) begin
                        state_reg <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: if (out_ready) begin
                    state_reg <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_stage.sv
// Scoreboard bench for fp_align_stage: random and directed operand pairs are
// checked against an arithmetic model of the alignment rules.
module tb_fp_align_stage;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_a_sign, out_b_sign, out_op, out_sticky, out_special;
    logic [23:0] out_a_mant, out_b_mant;
    logic [7:0]  out_exp;

    fp_align_stage #(.STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a_sign(out_a_sign), .out_b_sign(out_b_sign),
        .out_a_mant(out_a_mant), .out_b_mant(out_b_mant),
        .out_exp(out_exp), .out_op(out_op),
        .out_sticky(out_sticky), .out_special(out_special)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        as, bs, op, st, sp;
        logic [23:0] am, bm;
        logic [7:0]  ex;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cycle = 0;
    bit   seen = 0;
    bit   stall = 0;
    logic [23:0] last_am, last_bm;
    logic [7:0]  last_ex;
    logic        last_st, last_sp, last_op;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the unpacked fields.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_t r;
        int ea, eb, d, ma, mb, m;
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ma = int'({a[30:23] != 0, a[22:0]});
        mb = int'({b[30:23] != 0, b[22:0]});
        r.as = a[31]; r.bs = b[31]; r.op = op;
        r.sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        d = (ea > eb) ? ea - eb : eb - ea;
        r.ex = 8'((ea > eb) ? ea : eb);
        r.st = 1'b0;
        r.lat = 0;
        r.acc = 0;
        if (!r.sp && d > 0) begin
            m = (ea < eb) ? ma : mb;
            if (d >= 25) begin
                r.st = (m != 0);
                m = 0;
            end else begin
                r.st = (m % (1 << d)) != 0;
                m = m / (1 << d);
                r.lat = (d + STEP - 1) / STEP;
            end
            if (ea < eb) ma = m; else mb = m;
        end
        r.am = 24'(ma);
        r.bm = 24'(mb);
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops on the first valid cycle, re-checks every held cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid) begin
            if (!seen) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_out_valid: got 1, expected 0 (t=%0t)", $time);
                end else begin
                    cur = q.pop_front();
                    seen = 1;
                    chk("latency", 32'(cycle - cur.acc), 32'(cur.lat));
                end
            end
            if (seen) begin
                chk("a_sign", 32'(out_a_sign), 32'(cur.as));
                chk("b_sign", 32'(out_b_sign), 32'(cur.bs));
                chk("a_mant", 32'(out_a_mant), 32'(cur.am));
                chk("b_mant", 32'(out_b_mant), 32'(cur.bm));
                chk("exp", 32'(out_exp), 32'(cur.ex));
                chk("op", 32'(out_op), 32'(cur.op));
                chk("sticky", 32'(out_sticky), 32'(cur.st));
                chk("special", 32'(out_special), 32'(cur.sp));
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                last_am = out_a_mant; last_bm = out_b_mant; last_ex = out_exp;
                last_st = out_sticky; last_sp = out_special; last_op = out_op;
                if (out_ready) seen = 0;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
        exp_t e;
        int i;
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (i = 0; i < 300 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(a, b, op);
        e.acc = cycle + 1;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 500; i++) begin
            if (q.size() == 0 && !seen) return;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_word(input int e);
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    initial begin
        int ea, eb, mode;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {out_a_mant, out_exp}, 32'd0);
        rst_n = 1'b1;

        send(32'h3F800000, 32'h3F000000, 1'b0);
        wait_done();
        chk("t1_a_mant", 32'(last_am), 32'h800000);
        chk("t1_b_mant", 32'(last_bm), 32'h400000);
        chk("t1_exp", 32'(last_ex), 32'd127);
        chk("t1_sticky", 32'(last_st), 32'd0);

        send(32'h3F800000, 32'h3A800000, 1'b1);
        wait_done();
        chk("t2_b_mant", 32'(last_bm), 32'h002000);
        chk("t2_sticky", 32'(last_st), 32'd0);
        chk("t2_op", 32'(last_op), 32'd1);

        send(32'h3F800000, 32'h34400000, 1'b0);
        wait_done();
        chk("t3_b_mant", 32'(last_bm), 32'h000001);
        chk("t3_sticky", 32'(last_st), 32'd1);

        send(32'h3F800000, 32'h00000001, 1'b0);
        wait_done();
        chk("t4_b_mant", 32'(last_bm), 32'd0);
        chk("t4_sticky", 32'(last_st), 32'd1);
        chk("t4_exp", 32'(last_ex), 32'd127);

        send(32'h7F800000, 32'h3F800000, 1'b0);
        wait_done();
        chk("t5_special", 32'(last_sp), 32'd1);
        chk("t5_a_mant", 32'(last_am), 32'h800000);
        chk("t5_b_mant", 32'(last_bm), 32'h800000);

        for (int n = 0; n < 200; n++) begin
            mode = int'($urandom_range(0, 5));
            ea = int'($urandom_range(0, 254));
            case (mode)
                0: eb = ea;
                1: eb = ea + (($urandom_range(0, 1) != 0) ? 1 : -1) * int'($urandom_range(1, 26));
                2: eb = int'($urandom_range(0, 254));
                3: eb = 255;
                4: begin ea = 0; eb = int'($urandom_range(0, 2)); end
                default: eb = ea + int'($urandom_range(1, 9));
            endcase
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 254;
            send(rand_word(ea), rand_word(eb), 1'($urandom_range(0, 1)));
        end
        wait_done();

        // Backpressure: held result, second request ignored while busy.
        stall = 1;
        send(32'h3F800000, 32'h3F000000, 1'b0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_a = 32'h40400000; in_b = 32'h00000000; in_op = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_a_mant", 32'(out_a_mant), 32'h800000);
        end
        in_valid = 1'b0;
        stall = 0;
        wait_done();
        repeat (4) @(negedge clk);
        chk("bp_no_second", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a long shift.
        send(32'h3F800000, 32'h34400000, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        seen = 0;
        #1;
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_mants", {8'd0, out_a_mant | out_b_mant}, 32'd0);
        chk("ar_misc", 32'({out_exp, out_op, out_sticky, out_special, out_a_sign, out_b_sign}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("ar_no_valid", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
